// File: rtl/instr_fetch.sv
// instr_fetch: five-state MAR/MBR/IR fetch unit with jump redirect and ir_valid/ir_ready handshake.
// Optional sticky pc_wrap flag is built only when INSTR_FETCH_WRAP_FLAG_EN is defined.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  input  logic        ir_ready,
  output logic        ir_valid,
  output logic [15:0] ir_out,
  output logic [3:0]  opcode,
  output logic [11:0] operand_addr,
  output logic [15:0] pc_out,
  output logic        pc_wrap
);
  typedef enum logic [2:0] {S_ADDR, S_READ, S_MBR, S_IR, S_HOLD} state_t;
  state_t state;
  logic [15:0] pc, mar, mbr, ir;
  // jump overrides every state, discarding any in-flight or held instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_ADDR;
      pc       <= RESET_PC;
      mar      <= '0;
      mbr      <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (jump) begin
      state    <= S_ADDR;
      pc       <= jump_addr;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          mar   <= pc;
          state <= S_READ;
        end
        S_READ: state <= S_MBR;
        S_MBR: begin
          mbr   <= mem_rdata;
          state <= S_IR;
        end
        S_IR: begin
          ir       <= mbr;
          pc       <= pc + 16'd1;
          ir_valid <= 1'b1;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= S_ADDR;
          end
        end
        default: state <= S_ADDR;
      endcase
    end
  end
  assign mem_addr     = mar;
  assign ir_out       = ir;
  assign opcode       = ir[15:12];
  assign operand_addr = ir[11:0];
  assign pc_out       = pc;
`ifdef INSTR_FETCH_WRAP_FLAG_EN
  logic wrap;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap <= 1'b0;
    else if (state == S_IR && !jump && pc == 16'hFFFF) wrap <= 1'b1;
  end
  assign pc_wrap = wrap;
`else
  assign pc_wrap = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed plus randomized checks of instr_fetch against a transaction-level fetch model.
module tb_instr_fetch;
  logic clk = 1'b0, reset = 1'b1, jump = 1'b0, ir_ready = 1'b0;
  logic [15:0] jump_addr = '0, mem_rdata, hi_rdata;
  logic [15:0] mem_addr, ir_out, pc_out, hi_addr, hi_ir_out, hi_pc_out;
  logic [3:0]  opcode, hi_opcode;
  logic [11:0] operand_addr, hi_operand;
  logic ir_valid, pc_wrap, hi_ir_valid, hi_pc_wrap;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [15:0] mem [0:65535];
  logic [15:0] m_pc, m_ir;
  bit m_valid, m_wrap;
  int m_wait;
`ifdef INSTR_FETCH_WRAP_FLAG_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .jump(jump), .jump_addr(jump_addr), .ir_ready(ir_ready), .ir_valid(ir_valid),
    .ir_out(ir_out), .opcode(opcode), .operand_addr(operand_addr),
    .pc_out(pc_out), .pc_wrap(pc_wrap)
  );

  instr_fetch #(.RESET_PC(16'hFFFF)) u_hi (
    .clk(clk), .reset(reset), .mem_addr(hi_addr), .mem_rdata(hi_rdata),
    .jump(1'b0), .jump_addr(16'h0000), .ir_ready(1'b1), .ir_valid(hi_ir_valid),
    .ir_out(hi_ir_out), .opcode(hi_opcode), .operand_addr(hi_operand),
    .pc_out(hi_pc_out), .pc_wrap(hi_pc_wrap)
  );

  // synchronous-read memory: data appears on the edge after the address
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    hi_rdata  <= mem[hi_addr];
  end

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_ir = 16'h0000;
    m_valid = 1'b0;
    m_wrap = 1'b0;
    m_wait = 4;
  endtask

  // an instruction issues four edges after its fetch starts; it stays until consumed or redirected
  task automatic step(bit j, logic [15:0] ja, bit rdy);
    if (j) begin
      m_pc = ja;
      m_valid = 1'b0;
      m_wait = 4;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        m_wait = 4;
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_ir = mem[m_pc];
        if (m_pc == 16'hFFFF && WRAP_EN) m_wrap = 1'b1;
        m_pc = m_pc + 16'd1;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic cyc(bit j, logic [15:0] ja, bit rdy);
    jump = j;
    jump_addr = ja;
    ir_ready = rdy;
    @(posedge clk);
    if (!reset) step(j, ja, rdy);
    @(negedge clk);
    jump = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_ir_valid", 16'(ir_valid), 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_pc_wrap", 16'(pc_wrap), 16'h0000);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ir_valid", 16'(ir_valid), 16'(m_valid));
      chk("pc_out", pc_out, m_pc);
      chk("pc_wrap", 16'(pc_wrap), 16'(m_wrap));
      if (m_valid) begin
        chk("ir_out", ir_out, m_ir);
        chk("opcode", 16'(opcode), 16'(m_ir[15:12]));
        chk("operand_addr", 16'(operand_addr), 16'(m_ir[11:0]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h2345;
    mem[16'h0040] = 16'hA00F;
    mem[16'h0100] = 16'h5A5A;
    mem[16'hFFFF] = 16'hC0DE;
    model_reset();
    reset = 1'b1;
    ir_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ir_valid", 16'(ir_valid), 16'h0000);
    chk("reset_pc_out", pc_out, 16'h0000);
    chk("reset_ir_out", ir_out, 16'h0000);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_pc_wrap", 16'(pc_wrap), 16'h0000);
    chk("reset_hi_pc_out", hi_pc_out, 16'hFFFF);
    reset = 1'b0;
    chk_en = 1'b1;
    // first fetch from address 0
    repeat (3) cyc(1'b0, 16'h0000, 1'b1);
    chk("valid_before_4th_edge", 16'(ir_valid), 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("first_ir_valid", 16'(ir_valid), 16'h0001);
    chk("first_ir_out", ir_out, 16'h1234);
    chk("first_opcode", 16'(opcode), 16'h0001);
    chk("first_operand", 16'(operand_addr), 16'h0234);
    chk("first_pc_out", pc_out, 16'h0001);
    chk("hi_first_ir_out", hi_ir_out, 16'hC0DE);
    chk("hi_first_pc_out", hi_pc_out, 16'h0000);
    chk("hi_first_pc_wrap", 16'(hi_pc_wrap), 16'(WRAP_EN));
    // stall for ten cycles
    repeat (10) cyc(1'b0, 16'h0000, 1'b0);
    chk("stall_ir_out", ir_out, 16'h1234);
    chk("stall_pc_out", pc_out, 16'h0001);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("consume_ir_valid", 16'(ir_valid), 16'h0000);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0);
    chk("second_not_yet", 16'(ir_valid), 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("second_ir_out", ir_out, 16'h2345);
    chk("second_pc_out", pc_out, 16'h0002);
    // jump on the consuming edge
    cyc(1'b1, 16'h0100, 1'b1);
    chk("jump_consume_valid", 16'(ir_valid), 16'h0000);
    chk("jump_consume_pc", pc_out, 16'h0100);
    repeat (4) cyc(1'b0, 16'h0000, 1'b0);
    chk("jump_target_ir_out", ir_out, 16'h5A5A);
    chk("jump_target_pc", pc_out, 16'h0101);
    // jump while the fetch sits in the MBR stage
    cyc(1'b0, 16'h0000, 1'b1);
    repeat (2) cyc(1'b0, 16'h0000, 1'b0);
    cyc(1'b1, 16'h0040, 1'b0);
    chk("jump_mbr_valid", 16'(ir_valid), 16'h0000);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0);
    chk("jump_mbr_still_low", 16'(ir_valid), 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("jump_mbr_ir_out", ir_out, 16'hA00F);
    chk("jump_mbr_pc", pc_out, 16'h0041);
    chk("hi_wrap_sticky", 16'(hi_pc_wrap), 16'(WRAP_EN));
    // wrap via jump to the top address
    cyc(1'b1, 16'hFFFF, 1'b1);
    chk("jump_no_wrap", 16'(pc_wrap), 16'h0000);
    repeat (4) cyc(1'b0, 16'h0000, 1'b0);
    chk("wrap_pc_out", pc_out, 16'h0000);
    chk("wrap_ir_out", ir_out, 16'hC0DE);
    chk("wrap_flag", 16'(pc_wrap), 16'(WRAP_EN));
    // asynchronous reset while holding a valid instruction
    async_reset();
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else cyc($urandom_range(0, 15) == 0,
               ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
               1'($urandom_range(0, 1)));
    end
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
